load_store_unit: RTL
====================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter CAPACITY_BYTES, default 128, meaning byte capacity of the downstream block memory.
REQ-002 SHALL have parameter WORD_BYTES, default 4, meaning memory word width in bytes; only 4 is supported.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on posedge clk.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports req_valid in 1, req_ready out 1, req_write in 1, req_size in 2 (00 byte, 01 half, 10 word, 11 reserved), req_signed in 1, req_address in 32, req_wr_data in 32.
REQ-006 SHALL have ports resp_valid out 1, resp_ready in 1, resp_rd_data out 32, resp_error out 1.
REQ-007 SHALL have ports mem_address out $clog2(CAPACITY_BYTES), mem_rd_en out 1, mem_wr_data out 32, mem_wr_en out 4 (byte lanes), mem_rd_data in 32 (registered memory output, valid one cycle after mem_rd_en).

Function
REQ-008 SHALL implement FSM states IDLE, READ_WAIT, RESP.
REQ-009 SHALL assert req_ready only in IDLE with reset low; a request is accepted when req_valid && req_ready.
REQ-010 SHALL drive mem_* combinationally from the request only in the accept cycle; otherwise mem_rd_en=0, mem_wr_en=0.
REQ-011 Store accept SHALL drive mem_wr_en = byte 4'b0001<<a[1:0], half 4'b0011<<a[1:0], word 4'b1111; IDLE->RESP; resp_valid one cycle after accept.
REQ-012 Store data SHALL be lane-replicated: byte to all four lanes, half to both halves, word unchanged.
REQ-013 Load accept SHALL pulse mem_rd_en; IDLE->READ_WAIT; READ_WAIT captures mem_rd_data, ->RESP; resp_valid two cycles after accept.
REQ-014 Load data SHALL be shifted right by 8*a[1:0], then zero-extended (req_signed=0) or sign-extended (req_signed=1) from 8/16 bits; word returned unchanged.
REQ-015 RESP SHALL hold resp_valid, resp_rd_data, resp_error stable until resp_ready; on handshake ->IDLE, resp_valid=0 next cycle.
REQ-016 Store responses SHALL report resp_rd_data=0, resp_error=0.
REQ-017 req_address >= CAPACITY_BYTES or req_size=11 SHALL produce resp_error=1, resp_rd_data=0, no memory access, IDLE->RESP.
REQ-018 No new request SHALL be accepted while in READ_WAIT or RESP (one outstanding transaction).

Reset
REQ-019 reset SHALL force IDLE, resp_valid=0, resp_error=0, resp_rd_data=0, req_ready=0, mem_rd_en=0, mem_wr_en=0 in the same cycle.
REQ-020 reset in READ_WAIT or RESP SHALL abandon the transaction; no response is ever issued for it.

Configuration
REQ-021 Macro LSU_MISALIGN_TRAP_EN defined: misaligned half (a[0]=1) or word (a[1:0]!=0) SHALL produce resp_error=1, resp_rd_data=0, no memory access.
REQ-022 Macro undefined: misaligned accesses SHALL be silently aligned (half clears a[0], word clears a[1:0]) and performed with resp_error=0.

Structure
REQ-023 Package mem_pkg SHALL hold typedef mem_size_t (SIZE_BYTE, SIZE_HALF, SIZE_WORD, SIZE_RSVD), typedef lsu_state_t, and constant WORD_BYTES=4.
REQ-024 Combinational load extract/extend SHALL be sub-module lsu_load_align; FSM, masking and store replication stay in load_store_unit.

Verification
REQ-025 Store byte 0xA5 to 0x06 -> mem_wr_en=0100, mem_wr_data=0xA5A5A5A5, resp_valid at T+1, resp_error=0.
REQ-026 Memory word 0x80FF7F01 at 0x04; load signed byte 0x07 -> 0xFFFFFF80; unsigned half 0x06 -> 0x000080FF; both at T+2.
REQ-027 Load word 0x0A: with LSU_MISALIGN_TRAP_EN -> resp_error=1, data 0, mem_rd_en never high; without -> reads 0x08, resp_error=0.
REQ-028 Load at 0x80 (CAPACITY_BYTES=128) -> resp_error=1, no mem_rd_en pulse; same for req_size=11.
REQ-029 Hold resp_ready=0 5 cycles with req_valid=1 -> response stable, req_ready=0, no second accept; reset in READ_WAIT -> IDLE, no resp_valid.

Source files
------------

// File: rtl/mem_pkg.sv
// mem_pkg: shared types and constants for the load/store unit.
//   mem_size_t  : request access size encoding (byte, half, word, reserved)
//   lsu_state_t : load/store unit FSM state encoding
//   WORD_BYTES  : memory word width in bytes (only 4 is supported)
package mem_pkg;

    localparam int WORD_BYTES = 4;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10,
        SIZE_RSVD = 2'b11
    } mem_size_t;

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        READ_WAIT = 2'b01,
        RESP      = 2'b10
    } lsu_state_t;

endpackage

// File: rtl/lsu_load_align.sv
// lsu_load_align: combinational extraction of a load result from a memory word.
// The word is shifted right by 8*offset, then the low byte/half is zero- or
// sign-extended; word loads pass through unchanged.
// Ports:
//   rd_word_i  [31:0] raw memory word
//   offset_i   [1:0]  byte offset of the access within the word
//   size_i     [1:0]  access size (mem_size_t encoding)
//   signed_i          1 = sign-extend, 0 = zero-extend
//   data_o     [31:0] aligned and extended load result
module lsu_load_align
    import mem_pkg::*;
(
    input  logic [31:0] rd_word_i,
    input  logic [1:0]  offset_i,
    input  logic [1:0]  size_i,
    input  logic        signed_i,
    output logic [31:0] data_o
);

    logic [31:0] shifted;

    always_comb begin
        shifted = rd_word_i >> {offset_i, 3'b000};
        data_o  = shifted;
        case (mem_size_t'(size_i))
            SIZE_BYTE: data_o = {{24{signed_i & shifted[7]}}, shifted[7:0]};
            SIZE_HALF: data_o = {{16{signed_i & shifted[15]}}, shifted[15:0]};
            default:   data_o = shifted;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding load/store front end for a byte-lane
// block memory with a one-cycle registered read port.
// Optional feature: define LSU_MISALIGN_TRAP_EN to turn misaligned half/word
// accesses into error responses; otherwise they are silently aligned down.
// Ports:
//   clk, reset                     clock, synchronous active-high reset
//   req_valid/req_ready            request handshake
//   req_write, req_size, req_signed, req_address, req_wr_data  request payload
//   resp_valid/resp_ready          response handshake
//   resp_rd_data, resp_error       response payload
//   mem_address, mem_rd_en, mem_wr_data, mem_wr_en, mem_rd_data  memory port
//   dbg_state                      current FSM state (lsu_state_t encoding)
//
// Handshakes: a transfer happens on a rising edge where valid && ready are both
// high; the sender keeps valid and payload stable until that edge, and ready
// never depends combinationally on valid.
module load_store_unit #(
    parameter int CAPACITY_BYTES = 128,
    parameter int WORD_BYTES     = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              req_valid,
    output logic                              req_ready,
    input  logic                              req_write,
    input  logic [1:0]                        req_size,
    input  logic                              req_signed,
    input  logic [31:0]                       req_address,
    input  logic [31:0]                       req_wr_data,
    output logic                              resp_valid,
    input  logic                              resp_ready,
    output logic [31:0]                       resp_rd_data,
    output logic                              resp_error,
    output logic [$clog2(CAPACITY_BYTES)-1:0] mem_address,
    output logic                              mem_rd_en,
    output logic [31:0]                       mem_wr_data,
    output logic [3:0]                        mem_wr_en,
    input  logic [31:0]                       mem_rd_data,
    output logic [1:0]                        dbg_state
);

    localparam int AW = $clog2(CAPACITY_BYTES);
    localparam int OB = $clog2(WORD_BYTES);

    mem_pkg::lsu_state_t state_q, state_d;
    logic [31:0]         rsp_data_q, rsp_data_d;
    logic                rsp_err_q, rsp_err_d;
    logic [1:0]          ld_size_q, ld_size_d;
    logic                ld_signed_q, ld_signed_d;
    logic [OB-1:0]       ld_off_q, ld_off_d;

    mem_pkg::mem_size_t  size;
    logic [AW-1:0]       addr_aligned;
    logic                req_err;
    logic                accept;
    logic [3:0]          lane_mask;
    logic [31:0]         load_data;

    lsu_load_align u_align (
        .rd_word_i (mem_rd_data),
        .offset_i  (ld_off_q),
        .size_i    (ld_size_q),
        .signed_i  (ld_signed_q),
        .data_o    (load_data)
    );

    // Request decode: error detection, address alignment, memory drive.
    always_comb begin
        size         = mem_pkg::mem_size_t'(req_size);
        addr_aligned = req_address[AW-1:0];
        if (size == mem_pkg::SIZE_HALF) addr_aligned[0] = 1'b0;
        if (size == mem_pkg::SIZE_WORD) addr_aligned[OB-1:0] = '0;

        req_err = (req_address >= 32'(CAPACITY_BYTES)) || (size == mem_pkg::SIZE_RSVD);
`ifdef LSU_MISALIGN_TRAP_EN
        if ((size == mem_pkg::SIZE_HALF && req_address[0]) ||
            (size == mem_pkg::SIZE_WORD && req_address[OB-1:0] != '0))
            req_err = 1'b1;
`endif

        req_ready = (state_q == mem_pkg::IDLE) && !reset;
        accept    = req_valid && req_ready;

        case (size)
            mem_pkg::SIZE_BYTE: lane_mask = 4'b0001;
            mem_pkg::SIZE_HALF: lane_mask = 4'b0011;
            mem_pkg::SIZE_WORD: lane_mask = 4'b1111;
            default:            lane_mask = 4'b0000;
        endcase

        mem_address = '0;
        mem_rd_en   = 1'b0;
        mem_wr_en   = 4'b0000;
        mem_wr_data = '0;
        if (accept && !req_err) begin
            mem_address = addr_aligned;
            if (req_write) begin
                mem_wr_en = 4'(lane_mask << addr_aligned[1:0]);
                // Replicate narrow data so every enabled lane sees it.
                case (size)
                    mem_pkg::SIZE_BYTE: mem_wr_data = {4{req_wr_data[7:0]}};
                    mem_pkg::SIZE_HALF: mem_wr_data = {2{req_wr_data[15:0]}};
                    default:            mem_wr_data = req_wr_data;
                endcase
            end else begin
                mem_rd_en = 1'b1;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_d     = state_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        ld_size_d   = ld_size_q;
        ld_signed_d = ld_signed_q;
        ld_off_d    = ld_off_q;
        case (state_q)
            mem_pkg::IDLE: begin
                if (accept) begin
                    rsp_data_d = '0;
                    rsp_err_d  = req_err;
                    if (req_err || req_write) begin
                        state_d = mem_pkg::RESP;
                    end else begin
                        ld_size_d   = req_size;
                        ld_signed_d = req_signed;
                        ld_off_d    = addr_aligned[OB-1:0];
                        state_d     = mem_pkg::READ_WAIT;
                    end
                end
            end
            mem_pkg::READ_WAIT: begin
                // Memory data is valid exactly in this cycle.
                rsp_data_d = load_data;
                rsp_err_d  = 1'b0;
                state_d    = mem_pkg::RESP;
            end
            mem_pkg::RESP: begin
                if (resp_ready) state_d = mem_pkg::IDLE;
            end
            default: state_d = mem_pkg::IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= mem_pkg::IDLE;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            ld_size_q   <= '0;
            ld_signed_q <= 1'b0;
            ld_off_q    <= '0;
        end else begin
            state_q     <= state_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            ld_size_q   <= ld_size_d;
            ld_signed_q <= ld_signed_d;
            ld_off_q    <= ld_off_d;
        end
    end

    // Response outputs are forced low while reset is high, even mid-cycle.
    assign resp_valid   = (state_q == mem_pkg::RESP) && !reset;
    assign resp_rd_data = resp_valid ? rsp_data_q : 32'h0;
    assign resp_error   = resp_valid && rsp_err_q;
    assign dbg_state    = state_q;

endmodule
